// File: rtl/pipe_pulse_checker.sv
// Receive-end monitor for a pipe pulse chain. It measures the latency from the head
// trigger (start) to the tail pulse (pipe_in), and flags timeouts and spurious pulses.
module pipe_pulse_checker #(
  parameter int CNT_W   = 8,
  parameter int EXP_LAT = 2,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pipe_in,
  output logic             busy,
  output logic             done,
  output logic             lat_ok,
  output logic [CNT_W-1:0] latency,
  output logic             timeout,
  output logic             spurious,
  output logic [15:0]      pulse_count,
  output logic             dbg_state_o
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] EXP_C = CNT_W'(EXP_LAT);
  localparam logic [CNT_W-1:0] TMO_C = CNT_W'(TIMEOUT);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] latency_q;
  logic [15:0]      pcount_q;
  logic             start_prev_q;
  logic             pipe_prev_q;
  logic             busy_q;
  logic             done_q;
  logic             lat_ok_q;
  logic             timeout_q;
  logic             spurious_q;

  logic st_edge;
  logic p_edge;

  assign st_edge = start & ~start_prev_q;
  assign p_edge  = pipe_in & ~pipe_prev_q;

  // Handshake-free monitor: every output is a register. done/timeout/spurious are
  // high for exactly the one cycle after the edge that decided them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      latency_q    <= '0;
      pcount_q     <= '0;
      start_prev_q <= 1'b0;
      pipe_prev_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lat_ok_q     <= 1'b0;
      timeout_q    <= 1'b0;
      spurious_q   <= 1'b0;
    end else begin
      start_prev_q <= start;
      pipe_prev_q  <= pipe_in;
      done_q       <= 1'b0;
      timeout_q    <= 1'b0;
      spurious_q   <= 1'b0;

      if (p_edge && (pcount_q != 16'hFFFF)) begin
        pcount_q <= pcount_q + 16'd1;
      end

      case (state_q)
        IDLE: begin
          if (p_edge) begin
            spurious_q <= 1'b1;
          end
          if (st_edge) begin
            cnt_q   <= {{(CNT_W-1){1'b0}}, 1'b1};
            state_q <= WAIT;
            busy_q  <= 1'b1;
          end
        end
        WAIT: begin
          if (p_edge || (cnt_q == TMO_C)) begin
            if (p_edge) begin
              latency_q <= cnt_q;
              lat_ok_q  <= (cnt_q == EXP_C);
              done_q    <= 1'b1;
            end else begin
              lat_ok_q  <= 1'b0;
              timeout_q <= 1'b1;
            end
            // A trigger on the closing edge starts the next measurement at once.
            if (st_edge) begin
              cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign lat_ok      = lat_ok_q;
  assign latency     = latency_q;
  assign timeout     = timeout_q;
  assign spurious    = spurious_q;
  assign pulse_count = pcount_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/pipe_pulse_checker.md
Name: pipe_pulse_checker

Overview:
- Receive-end monitor for a chain of pipe pulse generator stages.
- Watches the trigger injected at the head of the chain (`start`) and the pulse emerging at the tail (`pipe_in`).
- Measures head-to-tail latency in clock cycles and compares it against an expected value.
- Flags timeouts and spurious pulses, and keeps a running pulse count, for bring-up and self-test of pulse chains.

Parameters:
- CNT_W, 8: width of the latency counter and the `latency` output.
- EXP_LAT, 2: expected latency in cycles. For N stages of width W the value is N*(W+1); the default covers one stage with W=1.
- TIMEOUT, 64: maximum latency accepted. Must satisfy EXP_LAT <= TIMEOUT <= 2^CNT_W-1.

Ports:
- clk, input, 1: clock; all logic on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: head-of-chain trigger level; only its rising edge matters.
- pipe_in, input, 1: tail-of-chain pulse level; only its rising edge matters.
- busy, output, 1: high while waiting for the tail pulse.
- done, output, 1: one-cycle pulse when a measurement completes.
- lat_ok, output, 1: latency == EXP_LAT for the last completed measurement; holds until the next completion or timeout.
- latency, output, CNT_W: last measured latency; holds until the next completion.
- timeout, output, 1: one-cycle pulse when no tail pulse arrives within TIMEOUT.
- spurious, output, 1: one-cycle pulse when a tail pulse arrives while not armed.
- pulse_count, output, 16: count of `pipe_in` rising edges; saturates at 0xFFFF.

Behaviour:
- Edge detection:
  - Registered `start_prev` and `pipe_prev`, both cleared by reset.
  - st_edge = start & ~start_prev.
  - p_edge = pipe_in & ~pipe_prev.
- Reset:
  - State IDLE, counter = 0.
  - busy = done = timeout = spurious = lat_ok = 0.
  - latency = 0, pulse_count = 0.
  - Reset asserted mid-measurement aborts it with no done or timeout pulse.
- Timing reference:
  - T0 is the edge at which st_edge = 1 is sampled while IDLE.
  - A p_edge sampled at edge T0+L gives latency L.
- State IDLE:
  - st_edge: counter <= 1, go to WAIT, busy = 1 from T0 onward.
  - p_edge: spurious pulses high for one cycle.
  - st_edge and p_edge at the same edge: both actions happen, and the pulse is not used as the tail pulse.
- State WAIT, evaluated at each edge in this order:
  1. p_edge: latency <= counter, lat_ok <= (counter == EXP_LAT), done pulses, go to IDLE.
  2. Otherwise, if counter == TIMEOUT: timeout pulses, lat_ok <= 0, latency unchanged, go to IDLE.
  3. Otherwise: counter increments.
- WAIT boundary cases:
  - A pulse at the same edge the counter reaches TIMEOUT is accepted (rule 1 wins).
  - st_edge in WAIT without completion is ignored; there is no restart and no overlap queueing.
  - st_edge at the same edge as a completion or timeout re-arms immediately: counter <= 1, stay in WAIT, busy stays 1.
- Output timing:
  - done, timeout and spurious are registered, high for exactly the cycle after the deciding edge, and never high together.
- pulse_count:
  - Increments on every p_edge in any state, spurious pulses included.
  - Stays at 0xFFFF once reached.
- Level inputs:
  - A `pipe_in` held high for several cycles counts once.
  - `start` must return low before it can trigger again.

Test Plan:
1. Single stage W=1 in the loop, EXP_LAT=2. Pulse `start` high for 1 cycle at T0 -> at T0+2 done=1, latency=2, lat_ok=1, busy falls, pulse_count=1.
2. Tail pulse delayed to L=5 -> done=1, latency=5, lat_ok=0. A following start with a correct L=2 -> lat_ok returns to 1.
3. No tail pulse, TIMEOUT=64 -> timeout=1 for one cycle after edge T0+64, latency keeps its previous value, lat_ok=0, back to IDLE. A pulse exactly at T0+64 instead -> done, latency=64.
4. `pipe_in` high for 3 cycles while IDLE -> spurious=1 for one cycle only, pulse_count increments by 1. The same pulse coinciding with st_edge -> spurious=1, busy=1, measurement continues.
5. Second st_edge at T0+1 -> ignored, done at T0+2 with latency 2. st_edge at the completion edge -> busy stays 1, next done measured from that edge.
6. Reset asserted at T0+1 -> all outputs 0 on the next cycle, no done or timeout. 65540 spurious pulses -> pulse_count holds at 0xFFFF.
